instr_ptr_stack: RTL and testbench
==================================

// Module: instr_ptr_stack
// PURPOSE
//   Parametrised instruction pointer with hardware return-address stack for the distributed processor core.
//   Adds call/return on top of the existing increment/hold/load behaviour.
//   Sits between the decoder (load/call/ret strobes, target address) and instruction memory (ptr_out = fetch address).
// PARAMETERS
//   PTR_WIDTH    8   width of pointer, load_val and every stack entry
//   STACK_DEPTH  4   return-stack entries (>=1); level counter is $clog2(STACK_DEPTH+1) bits
//   RESET_VAL    0   value of ptr_out after reset
// PORTS
//   clk          in   1          system clock, all state updates on rising edge
//   reset        in   1          asynchronous, active-high; clears all state immediately
//   enable       in   1          advance/update permitted this cycle; 0 = hold everything
//   load_enable  in   1          jump: ptr <= load_val
//   load_val     in   PTR_WIDTH  jump/call target
//   call_en      in   1          push ptr_out+1, ptr <= load_val
//   ret_en       in   1          ptr <= top of stack, pop
//   ptr_out      out  PTR_WIDTH  registered instruction pointer
//   stack_level  out  LVL_W      number of valid stack entries
//   stack_full   out  1          stack_level == STACK_DEPTH
//   stack_empty  out  1          stack_level == 0
// BEHAVIOUR
//   - Reset (any time, incl. mid-call): ptr_out=RESET_VAL, stack_level=0, all entries 0, empty=1, full=0, err flags 0.
//   - All outputs registered; 1-cycle latency from strobe to new ptr_out / stack_level.
//   - enable=0: ptr, stack, level all hold; strobes ignored (not queued).
//   - enable=1, priority per cycle: (ret&call) > ret > call > load > increment.
//     increment: ptr <= ptr_out+1, modulo 2^PTR_WIDTH (all-ones wraps to 0).
//     load:      ptr <= load_val; stack unchanged.
//     call:      push (ptr_out+1 mod 2^PTR_WIDTH); ptr <= load_val; level+1.
//     ret:       ptr <= top entry; level-1.
//     ret&call:  pop-then-push: top entry replaced by ptr_out+1, level unchanged, ptr <= load_val;
//                if empty, behaves as plain call.
//   - load_enable is ignored whenever call_en or ret_en is active.
//   - Call when full: ptr still jumps to load_val; push discarded, stack and level unchanged (overflow event).
//   - Ret when empty: ptr <= ptr_out+1, level stays 0 (underflow event).
//   - stack_full/stack_empty are decoded from the registered level, valid same cycle as stack_level.
// CONFIGURATION
//   INSTR_PTR_STACK_ERR_EN defined: extra outputs err_ovf, err_unf (1 bit each), sticky,
//     set the cycle after an overflow/underflow event, cleared only by reset.
//   Not defined: ports absent; overflow/underflow behave identically but are silent.
// STRUCTURE
//   - Shared header instr_ptr_defs.vh: localparams for next-ptr select encoding
//     (SEL_HOLD, SEL_INC, SEL_LOAD, SEL_CALL, SEL_RET, SEL_RETCALL), shared with the decoder.
//   - One sub-module: instr_ptr_ret_stack (LIFO: push, pop, push_data, top, level, full, empty, clk, reset).
//     Top level holds the ptr register and the priority mux.
// TESTING
//   1. Reset held, enable=1 -> ptr_out=0, level=0, empty=1. Release reset -> ptr increments 1,2,3 per cycle.
//      enable=0 for 3 cycles -> ptr frozen.
//   2. At ptr=5, call_en with load_val=40 -> ptr=40, level=1.
//      Run to 42, ret_en -> ptr=6, level=0, empty=1.
//   3. Nested calls with STACK_DEPTH=4: 4 calls -> full=1. 5th call to 90 -> ptr=90, level=4,
//      err_ovf=1 (macro on). 4 rets return in LIFO order.
//   4. ret_en while empty at ptr=17 -> ptr=18, level=0, err_unf=1 (macro on).
//      call_en+ret_en at ptr=20, level=1, load_val=60 -> ptr=60, level=1, top=21.
//   5. Wrap and priority: ptr=255 increment -> 0. Load to 255, then call to 3 -> pushed value 0.
//      load_enable+call_en together -> call taken, stack pushed.
//   6. Async reset mid-sequence (level=2, between clock edges) -> ptr_out=0, level=0 immediately, before next edge.

Source files
------------

// File: rtl/instr_ptr_stack_pkg.sv
// Shared definitions for the instruction pointer and its return-address stack.
// The next-pointer select encoding is shared with the decoder.
package instr_ptr_stack_pkg;

  typedef enum logic [2:0] {
    SEL_HOLD    = 3'd0,
    SEL_INC     = 3'd1,
    SEL_LOAD    = 3'd2,
    SEL_CALL    = 3'd3,
    SEL_RET     = 3'd4,
    SEL_RETCALL = 3'd5
  } ptr_sel_e;

  // Per-cycle priority: (ret&call) > ret > call > load > increment.
  // A return on an empty stack degrades to an increment, ret&call on empty to a call.
  function automatic ptr_sel_e next_sel(
    input logic enable,
    input logic load_enable,
    input logic call_en,
    input logic ret_en,
    input logic empty
  );
    ptr_sel_e sel;
    sel = SEL_HOLD;
    if (enable) begin
      if (ret_en && call_en)  sel = empty ? SEL_CALL : SEL_RETCALL;
      else if (ret_en)        sel = empty ? SEL_INC  : SEL_RET;
      else if (call_en)       sel = SEL_CALL;
      else if (load_enable)   sel = SEL_LOAD;
      else                    sel = SEL_INC;
    end
    return sel;
  endfunction

endpackage

// File: rtl/instr_ptr_ret_stack.sv
// LIFO return-address stack. push&pop together replaces the top entry;
// push when full and pop when empty are discarded.
module instr_ptr_ret_stack #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push,
  input  logic                           pop,
  input  logic [WIDTH-1:0]               push_data,
  output logic [WIDTH-1:0]               top,
  output logic [$clog2(DEPTH+1)-1:0]     level,
  output logic                           full,
  output logic                           empty
);

  localparam int unsigned LVL_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;
  logic             do_repl;

  assign empty = (level == '0);
  assign full  = (level == LVL_W'(DEPTH));

  // ret&call on an empty stack is a plain push; empty implies not full
  assign do_repl = push && pop && !empty;
  assign do_push = (push && !pop && !full) || (push && pop && empty);
  assign do_pop  = pop && !push && !empty;

  always_comb begin
    top = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (level == LVL_W'(i + 1)) top = mem[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (do_push && level == LVL_W'(i))     mem[i] <= push_data;
        if (do_repl && level == LVL_W'(i + 1)) mem[i] <= push_data;
      end
      if (do_push)     level <= level + LVL_W'(1);
      else if (do_pop) level <= level - LVL_W'(1);
    end
  end

endmodule

// File: rtl/instr_ptr_stack.sv
// Instruction pointer with hardware return-address stack (call/ret/load/increment).
// Define INSTR_PTR_STACK_ERR_EN to add sticky err_ovf/err_unf outputs.
module instr_ptr_stack #(
  parameter int unsigned PTR_WIDTH   = 8,
  parameter int unsigned STACK_DEPTH = 4,
  parameter logic [PTR_WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               enable,
  input  logic                               load_enable,
  input  logic [PTR_WIDTH-1:0]               load_val,
  input  logic                               call_en,
  input  logic                               ret_en,
  output logic [PTR_WIDTH-1:0]               ptr_out,
`ifdef INSTR_PTR_STACK_ERR_EN
  output logic                               err_ovf,
  output logic                               err_unf,
`endif
  output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_level,
  output logic                               stack_full,
  output logic                               stack_empty
);

  import instr_ptr_stack_pkg::*;

  ptr_sel_e             sel;
  logic [PTR_WIDTH-1:0] ptr_inc;
  logic [PTR_WIDTH-1:0] ptr_next;
  logic [PTR_WIDTH-1:0] stk_top;
  logic                 push;
  logic                 pop;

  assign ptr_inc = ptr_out + PTR_WIDTH'(1);
  assign sel     = next_sel(enable, load_enable, call_en, ret_en, stack_empty);
  assign push    = (sel == SEL_CALL) || (sel == SEL_RETCALL);
  assign pop     = (sel == SEL_RET)  || (sel == SEL_RETCALL);

  always_comb begin
    ptr_next = ptr_out;
    unique case (sel)
      SEL_HOLD:                       ptr_next = ptr_out;
      SEL_INC:                        ptr_next = ptr_inc;
      SEL_LOAD, SEL_CALL, SEL_RETCALL: ptr_next = load_val;
      SEL_RET:                        ptr_next = stk_top;
      default:                        ptr_next = ptr_out;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_out <= RESET_VAL;
    else       ptr_out <= ptr_next;
  end

  instr_ptr_ret_stack #(
    .WIDTH (PTR_WIDTH),
    .DEPTH (STACK_DEPTH)
  ) u_ret_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (ptr_inc),
    .top       (stk_top),
    .level     (stack_level),
    .full      (stack_full),
    .empty     (stack_empty)
  );

`ifdef INSTR_PTR_STACK_ERR_EN
  logic ovf_evt;
  logic unf_evt;

  assign ovf_evt = (sel == SEL_CALL) && stack_full;
  assign unf_evt = enable && ret_en && !call_en && stack_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
    end else begin
      if (ovf_evt) err_ovf <= 1'b1;
      if (unf_evt) err_unf <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_ptr_stack.sv
// Directed, table-driven bench for instr_ptr_stack (PTR_WIDTH=8, STACK_DEPTH=4).
module tb_instr_ptr_stack;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       load_enable;
  logic [7:0] load_val;
  logic       call_en;
  logic       ret_en;
  logic [7:0] ptr_out;
  logic [2:0] stack_level;
  logic       stack_full;
  logic       stack_empty;
`ifdef INSTR_PTR_STACK_ERR_EN
  logic       err_ovf;
  logic       err_unf;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  instr_ptr_stack #(
    .PTR_WIDTH   (8),
    .STACK_DEPTH (4),
    .RESET_VAL   (8'd0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .load_enable (load_enable),
    .load_val    (load_val),
    .call_en     (call_en),
    .ret_en      (ret_en),
    .ptr_out     (ptr_out),
`ifdef INSTR_PTR_STACK_ERR_EN
    .err_ovf     (err_ovf),
    .err_unf     (err_unf),
`endif
    .stack_level (stack_level),
    .stack_full  (stack_full),
    .stack_empty (stack_empty)
  );

  typedef struct {
    logic       en;
    logic       ld;
    logic       cl;
    logic       rt;
    logic [7:0] val;
    logic [7:0] eptr;
    logic [2:0] elvl;
  } vec_t;

  localparam int NV = 38;
  vec_t v [NV];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic setv(input int i, input logic en, input logic ld, input logic cl,
                      input logic rt, input int val, input int eptr, input int elvl);
    v[i].en   = en;
    v[i].ld   = ld;
    v[i].cl   = cl;
    v[i].rt   = rt;
    v[i].val  = 8'(val);
    v[i].eptr = 8'(eptr);
    v[i].elvl = 3'(elvl);
  endtask

  task automatic drive(input logic en, input logic ld, input logic cl,
                       input logic rt, input logic [7:0] val);
    enable      = en;
    load_enable = ld;
    call_en     = cl;
    ret_en      = rt;
    load_val    = val;
  endtask

  initial begin
    //        idx en ld cl rt val   ptr lvl
    setv( 0, 1, 0, 0, 0,   0,    1, 0);
    setv( 1, 1, 0, 0, 0,   0,    2, 0);
    setv( 2, 1, 0, 0, 0,   0,    3, 0);
    setv( 3, 0, 0, 1, 0,  99,    3, 0);   // strobes ignored while disabled
    setv( 4, 0, 1, 0, 0,  99,    3, 0);
    setv( 5, 0, 0, 0, 1,   0,    3, 0);
    setv( 6, 1, 0, 0, 0,   0,    4, 0);
    setv( 7, 1, 0, 0, 0,   0,    5, 0);
    setv( 8, 1, 0, 1, 0,  40,   40, 1);   // pushes 6
    setv( 9, 1, 0, 0, 0,   0,   41, 1);
    setv(10, 1, 0, 0, 0,   0,   42, 1);
    setv(11, 1, 0, 0, 1,   0,    6, 0);
    setv(12, 1, 0, 1, 0,  10,   10, 1);   // pushes 7
    setv(13, 1, 0, 1, 0,  20,   20, 2);   // pushes 11
    setv(14, 1, 0, 1, 0,  30,   30, 3);   // pushes 21
    setv(15, 1, 0, 1, 0,  50,   50, 4);   // pushes 31, full
    setv(16, 1, 0, 1, 0,  90,   90, 4);   // overflow: push discarded
    setv(17, 1, 0, 0, 1,   0,   31, 3);
    setv(18, 1, 0, 0, 1,   0,   21, 2);
    setv(19, 1, 0, 0, 1,   0,   11, 1);
    setv(20, 1, 0, 0, 1,   0,    7, 0);
    setv(21, 1, 1, 0, 0,  17,   17, 0);
    setv(22, 1, 0, 0, 1,   0,   18, 0);   // underflow
    setv(23, 1, 0, 1, 0,  20,   20, 1);   // pushes 19
    setv(24, 1, 0, 1, 1,  60,   60, 1);   // top replaced by 21
    setv(25, 1, 0, 0, 1,   0,   21, 0);
    setv(26, 1, 0, 1, 1,  70,   70, 1);   // empty: plain call, pushes 22
    setv(27, 1, 0, 0, 1,   0,   22, 0);
    setv(28, 1, 1, 0, 0, 254,  254, 0);
    setv(29, 1, 0, 0, 0,   0,  255, 0);
    setv(30, 1, 0, 0, 0,   0,    0, 0);   // wrap
    setv(31, 1, 1, 0, 0, 255,  255, 0);
    setv(32, 1, 0, 1, 0,   3,    3, 1);   // pushes 0
    setv(33, 1, 1, 1, 0, 100,  100, 2);   // call beats load, pushes 4
    setv(34, 1, 0, 0, 1,   0,    4, 1);
    setv(35, 1, 0, 0, 1,   0,    0, 0);
    setv(36, 1, 1, 0, 1,  77,    1, 0);   // ret beats load; empty -> increment
    setv(37, 0, 1, 0, 0,   9,    1, 0);

    reset = 1'b1;
    drive(1, 0, 0, 0, 8'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ptr",   int'(ptr_out), 0);
    chk("reset_level", int'(stack_level), 0);
    chk("reset_empty", int'(stack_empty), 1);
    chk("reset_full",  int'(stack_full), 0);
`ifdef INSTR_PTR_STACK_ERR_EN
    chk("reset_ovf", int'(err_ovf), 0);
    chk("reset_unf", int'(err_unf), 0);
`endif
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(v[i].en, v[i].ld, v[i].cl, v[i].rt, v[i].val);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_ptr", i),   int'(ptr_out), int'(v[i].eptr));
      chk($sformatf("v%0d_level", i), int'(stack_level), int'(v[i].elvl));
      chk($sformatf("v%0d_empty", i), int'(stack_empty), int'(v[i].elvl == 3'd0));
      chk($sformatf("v%0d_full", i),  int'(stack_full), int'(v[i].elvl == 3'd4));
`ifdef INSTR_PTR_STACK_ERR_EN
      chk($sformatf("v%0d_ovf", i), int'(err_ovf), int'(i >= 16));
      chk($sformatf("v%0d_unf", i), int'(err_unf), int'(i >= 22));
`endif
      @(negedge clk);
    end

    // Async reset between edges with two entries on the stack
    drive(1, 0, 1, 0, 8'd120);
    @(posedge clk);
    @(negedge clk);
    drive(1, 0, 1, 0, 8'd130);
    @(posedge clk);
    #1;
    chk("pre_rst_ptr",   int'(ptr_out), 130);
    chk("pre_rst_level", int'(stack_level), 2);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_ptr",   int'(ptr_out), 0);
    chk("async_rst_level", int'(stack_level), 0);
    chk("async_rst_empty", int'(stack_empty), 1);
`ifdef INSTR_PTR_STACK_ERR_EN
    chk("async_rst_ovf", int'(err_ovf), 0);
    chk("async_rst_unf", int'(err_unf), 0);
`endif
    @(negedge clk);
    reset = 1'b0;
    drive(1, 0, 0, 0, 8'd0);
    @(posedge clk);
    #1;
    chk("post_rst_inc", int'(ptr_out), 1);
    // Return after reset must underflow: entries were cleared
    @(negedge clk);
    drive(1, 0, 0, 1, 8'd0);
    @(posedge clk);
    #1;
    chk("post_rst_ret_ptr",   int'(ptr_out), 2);
    chk("post_rst_ret_level", int'(stack_level), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
